// File: rtl/boton_repeticion_pkg.sv
// boton_repeticion_pkg: state encodings and 50 MHz default timing for boton_repeticion
package boton_repeticion_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_REP  = 2'd2
  } state_t;
  localparam int DEF_HOLD_CYCLES   = 25_000_000;
  localparam int DEF_REPEAT_CYCLES = 5_000_000;
  localparam int DEF_CNT_W         = 25;
endpackage

// File: rtl/boton_repeticion.sv
// boton_repeticion: turns a debounced button level into press/auto-repeat/release pulses
// Ports: clk, reset (sync, active-high); i_sen button level (1=pressed, clk-synchronous);
//   i_enable (0 forces IDLE); o_press, o_rpt, o_step (press|rpt), o_release 1-cycle pulses;
//   o_held level from first repeat until release/disable. All outputs registered.
module boton_repeticion
  import boton_repeticion_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sen,
  input  logic i_enable,
  output logic o_press,
  output logic o_rpt,
  output logic o_step,
  output logic o_release,
  output logic o_held
);
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      ((HOLD_CYCLES - 1) >> CNT_W) != 0 || ((REPEAT_CYCLES - 1) >> CNT_W) != 0) begin : g_param_err
    $error("boton_repeticion: CNT_W too small or cycle counts below 1");
  end
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic r_sen_q, r_press, r_rpt, r_step, r_release, r_held;
  logic w_rise, w_fall, w_press_n, w_rpt_n, w_release_n, w_held_n;
  assign w_rise = i_sen & ~r_sen_q;
  assign w_fall = ~i_sen & r_sen_q;
  // One timer serves both the hold and the repeat phase; it restarts on each phase change.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt + 1'b1;
    w_press_n   = 1'b0;
    w_rpt_n     = 1'b0;
    w_release_n = 1'b0;
    w_held_n    = r_held;
    if (!i_enable) begin
      w_state_n = ST_IDLE;
      w_cnt_n   = '0;
      w_held_n  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_n   = '0;
          w_held_n  = 1'b0;
          w_press_n = w_rise;
          w_state_n = w_rise ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          if (w_fall) begin
            w_release_n = 1'b1;
            w_cnt_n     = '0;
            w_state_n   = ST_IDLE;
          end else if (r_cnt == HOLD_LAST) begin
            w_rpt_n   = 1'b1;
            w_held_n  = 1'b1;
            w_cnt_n   = '0;
            w_state_n = ST_REP;
          end
        end
        ST_REP: begin
          if (w_fall) begin
            w_release_n = 1'b1;
            w_held_n    = 1'b0;
            w_cnt_n     = '0;
            w_state_n   = ST_IDLE;
          end else if (r_cnt == REP_LAST) begin
            w_rpt_n = 1'b1;
            w_cnt_n = '0;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
          w_cnt_n   = '0;
          w_held_n  = 1'b0;
        end
      endcase
    end
  end
  // sen_q follows sen even during reset so a button held through reset yields no edge.
  always_ff @(posedge clk) begin
    r_sen_q <= i_sen;
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_rpt     <= 1'b0;
      r_step    <= 1'b0;
      r_release <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_press   <= w_press_n;
      r_rpt     <= w_rpt_n;
      r_step    <= w_press_n | w_rpt_n;
      r_release <= w_release_n;
      r_held    <= w_held_n;
    end
  end
  assign o_press   = r_press;
  assign o_rpt     = r_rpt;
  assign o_step    = r_step;
  assign o_release = r_release;
  assign o_held    = r_held;
endmodule
